// File: rtl/fifo_fwft_rd_if.sv
// Read-side stream bundle between the pointer/RAM stage, the FWFT output stage and the consumer.
interface fifo_fwft_rd_if #(
    parameter int unsigned DSIZE = 8
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;
    logic             flush;
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic [1:0]       occupancy;

    modport slave (
        input  rempty, rdata, flush, m_ready,
        output rinc, m_valid, m_data, occupancy
    );

    modport master (
        output rempty, rdata, flush, m_ready,
        input  rinc, m_valid, m_data, occupancy
    );
endinterface

// File: rtl/fifo_fwft_rd.sv
// First-word-fall-through read output stage: two-entry head/skid buffer feeding a
// registered valid/ready stream at one word per cycle.
module fifo_fwft_rd #(
    parameter int unsigned DSIZE = 8
) (
    input  logic                  rclk,
    input  logic                  rrst,
    fifo_fwft_rd_if.slave         bus
);
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DSIZE-1:0] e0_q, e0_d;
    logic [DSIZE-1:0] e1_q, e1_d;
    logic             take;
    logic             pop;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q <= StEmpty;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        // Space is decided by state alone so rinc never waits on m_ready.
        take    = ~bus.rempty & ~bus.flush & (state_q != StTwo);
        pop     = (state_q != StEmpty) & bus.m_ready & ~bus.flush;

        unique case (state_q)
            StEmpty: begin
                if (take) begin
                    e0_d    = bus.rdata;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (take && pop) begin
                    e0_d = bus.rdata;
                end else if (take) begin
                    e1_d    = bus.rdata;
                    state_d = StTwo;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    e0_d    = e1_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (bus.flush) begin
            state_d = StEmpty;
        end
    end

    // Gate with reset so the pointer stage sees no request while reset is held.
    assign bus.rinc      = take & ~rrst;
    assign bus.m_valid   = (state_q != StEmpty);
    assign bus.m_data    = e0_q;
    assign bus.occupancy = state_q;
endmodule
